mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the fetch stage (read-only) and the memory stage (read/write).
- Sequences each access through a small FSM and returns data with a one-cycle ready pulse.
- Generates the stall levels that freeze the fetch stage and the pipeline while their access is outstanding.
- Sits between the IF/MEM stages and the memory array; the hazard and PC control logic OR its stalls into theirs.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/mem_arb_priority.sv | 23 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, port owner, word width.
// Latency: none (types and constants only).
// Backpressure: none (no datapath).
package pipeline_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data ports: MEM wins unless it also won last time and IF waits.
// Latency: purely combinational.
// Backpressure: none; the loser simply stays unselected until a later IDLE evaluation.
module mem_arb_priority
   import pipeline_pkg::*;
(
   input  logic   if_req,
   input  logic   mem_req,
   input  owner_t last_grant,
   output logic   grant_valid,
   output owner_t grant_owner
);

   // Data port has priority; a fetch waiting behind a previous MEM grant gets the next turn.
   always_comb begin
      grant_valid = if_req | mem_req;
      grant_owner = OWN_IF;
      if (mem_req && !(if_req && (last_grant == OWN_MEM))) begin
         grant_owner = OWN_MEM;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between fetch (read) and data (read/write) ports.
// Latency: grant in cycle t, ram_en for t+1..t+LATENCY, one-cycle ready pulse in t+LATENCY+1.
// Backpressure: requesters hold their level request; stall_fetch/stall_pipe stay high until served.
module mem_port_arbiter
   import pipeline_pkg::*;
#(
   parameter int WIDTH   = WORD_W,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_ready,
   input  logic             mem_req,
   input  logic             mem_we,
   input  logic [WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0] mem_wdata,
   output logic [WIDTH-1:0] mem_rdata,
   output logic             mem_ready,
   output logic             ram_en,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0] ram_wdata,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic             stall_fetch,
   output logic             stall_pipe
);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   // The port that won the most recent grant doubles as the owner of the current access.
   owner_t           r_last_grant;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_we;
   logic [WIDTH-1:0] r_if_rdata;
   logic [WIDTH-1:0] r_mem_rdata;
   logic             w_grant_valid;
   owner_t           w_grant_owner;
   logic             w_last_beat;
   logic             w_grant;

   mem_arb_priority u_priority (
      .if_req      (if_req),
      .mem_req     (mem_req),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_owner (w_grant_owner)
   );

   assign w_last_beat = (r_cnt == '0);
   assign w_grant     = (r_state == ST_IDLE) && w_grant_valid;

   assign if_rdata    = r_if_rdata;
   assign mem_rdata   = r_mem_rdata;
   // Stalls track the raw request so a losing requester stays frozen until its own ready.
   assign stall_fetch = if_req & ~if_ready;
   assign stall_pipe  = mem_req & ~mem_ready;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and memory/ready outputs; memory bus is driven only during ACCESS.
   always_comb begin
      w_next_state = r_state;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
      if_ready     = 1'b0;
      mem_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ram_en    = 1'b1;
            ram_we    = r_we;
            ram_addr  = r_addr;
            ram_wdata = r_wdata;
            if (w_last_beat) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if_ready     = (r_last_grant == OWN_IF);
            mem_ready    = (r_last_grant == OWN_MEM);
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Grant-time capture of the winner's request, latency countdown, and read-data return.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_last_grant <= OWN_IF;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_if_rdata   <= '0;
         r_mem_rdata  <= '0;
      end else begin
         if (w_grant) begin
            r_last_grant <= w_grant_owner;
            r_cnt        <= CNT_W'(LATENCY - 1);
            if (w_grant_owner == OWN_MEM) begin
               r_addr  <= mem_addr;
               r_we    <= mem_we;
               r_wdata <= mem_wdata;
            end else begin
               r_addr  <= if_addr;
               r_we    <= 1'b0;
               r_wdata <= '0;
            end
         end
         if (r_state == ST_ACCESS) begin
            if (!w_last_beat) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end else if (!r_we) begin
               if (r_last_grant == OWN_IF) begin
                  r_if_rdata <= ram_rdata;
               end else begin
                  r_mem_rdata <= ram_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LATENCY=2 and LATENCY=1 instances against a transaction-level model.
// Latency: checks ready timing relative to request in whole clock cycles.
// Backpressure: requesters hold level requests and drop them the cycle after their ready pulse.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, mem_req, mem_we;
   logic [15:0] if_addr, mem_addr, mem_wdata;
   logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        if_ready, mem_ready, ram_en, ram_we, stall_fetch, stall_pipe;

   logic        if_req_1, mem_req_1, mem_we_1;
   logic [15:0] if_addr_1, mem_addr_1, mem_wdata_1;
   logic [15:0] if_rdata_1, mem_rdata_1, ram_addr_1, ram_wdata_1, ram_rdata_1;
   logic        if_ready_1, mem_ready_1, ram_en_1, ram_we_1, stall_fetch_1, stall_pipe_1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(16), .LATENCY(LAT), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_fetch(stall_fetch), .stall_pipe(stall_pipe)
   );

   mem_port_arbiter #(.WIDTH(16), .LATENCY(LAT1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
      .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
      .mem_rdata(mem_rdata_1), .mem_ready(mem_ready_1),
      .ram_en(ram_en_1), .ram_we(ram_we_1), .ram_addr(ram_addr_1), .ram_wdata(ram_wdata_1),
      .ram_rdata(ram_rdata_1), .stall_fetch(stall_fetch_1), .stall_pipe(stall_pipe_1)
   );

   // Deterministic power-on memory contents, shared by the memory and the reference model.
   function automatic logic [15:0] init_val(input int i);
      if (i == 4) return 16'h1234;
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   // Physical memory behind the LATENCY=2 instance: combinational read, write on clock edge.
   logic [15:0] ram_m [0:255];
   assign ram_rdata = ram_m[ram_addr[7:0]];
   initial begin
      for (int i = 0; i < 256; i++) ram_m[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (ram_en === 1'b1 && ram_we === 1'b1) ram_m[ram_addr[7:0]] <= ram_wdata;
      end
   end

   // Read-only memory behind the LATENCY=1 instance.
   assign ram_rdata_1 = init_val(int'(ram_addr_1[7:0])) ^ 16'hFFFF;

   // Reference memory image and expected port state, updated at transaction level.
   logic [15:0] ref_m [0:255];
   logic [15:0] exp_if, exp_mem;
   bit          last_mem;

   // Bus monitor: one record per ram_en burst.
   logic [15:0] bq_addr[$];
   logic [15:0] bq_wdata[$];
   logic        bq_we[$];
   int          bq_len[$];
   bit          bq_stable[$];
   bit          in_b = 0;
   logic [15:0] c_addr, c_wdata;
   logic        c_we;
   int          c_len;
   bit          c_stab;
   int          en1_cnt = 0;

   always @(negedge clk) begin
      if (ram_en === 1'b1) begin
         if (!in_b) begin
            in_b = 1; c_addr = ram_addr; c_we = ram_we; c_wdata = ram_wdata; c_len = 1; c_stab = 1;
         end else begin
            c_len++;
            if (ram_addr !== c_addr || ram_we !== c_we || ram_wdata !== c_wdata) c_stab = 0;
         end
      end else if (in_b) begin
         in_b = 0;
         bq_addr.push_back(c_addr); bq_we.push_back(c_we); bq_wdata.push_back(c_wdata);
         bq_len.push_back(c_len); bq_stable.push_back(c_stab);
      end
      if (ram_en_1 === 1'b1) en1_cnt++;
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1; if_req = 0; mem_req = 0; if_req_1 = 0; mem_req_1 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      last_mem = 0; exp_if = '0; exp_mem = '0;
   endtask

   // Drives one request on either or both ports of the LATENCY=2 instance and reports
   // the cycle index (0 = request cycle) at which each ready pulse was seen.
   task automatic drive_pair(input bit do_if, input bit do_mem, input logic [15:0] ia,
                             input logic mwe, input logic [15:0] ma, input logic [15:0] mwd,
                             output int if_cyc, output int mem_cyc,
                             output logic [15:0] if_d, output logic [15:0] mem_d,
                             output bit stall_ok, output bit timed_out);
      int cyc;
      bit if_busy, mem_busy;
      @(posedge clk); #1;
      if_req = do_if; if_addr = ia; mem_req = do_mem; mem_we = mwe; mem_addr = ma; mem_wdata = mwd;
      if_busy = do_if; mem_busy = do_mem; if_cyc = -1; mem_cyc = -1;
      if_d = '0; mem_d = '0; stall_ok = 1; cyc = 0;
      while ((if_busy || mem_busy) && cyc < 60) begin
         @(negedge clk);
         if (if_busy) begin
            if (if_ready === 1'b1) begin
               if_cyc = cyc; if_d = if_rdata;
               if (stall_fetch !== 1'b0) stall_ok = 0;
            end else if (stall_fetch !== 1'b1) stall_ok = 0;
         end
         if (mem_busy) begin
            if (mem_ready === 1'b1) begin
               mem_cyc = cyc; mem_d = mem_rdata;
               if (stall_pipe !== 1'b0) stall_ok = 0;
            end else if (stall_pipe !== 1'b1) stall_ok = 0;
         end
         @(posedge clk); #1;
         if (if_busy && if_cyc >= 0) begin if_req = 0; if_busy = 0; end
         if (mem_busy && mem_cyc >= 0) begin mem_req = 0; mem_busy = 0; end
         cyc++;
      end
      timed_out = if_busy || mem_busy;
      if_req = 0; mem_req = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_we, if_ready, mem_ready, stall_fetch, stall_pipe} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                            {ram_en, ram_we, if_ready, mem_ready, stall_fetch, stall_pipe});
      end
      n_checks++;
      if ({ram_addr, ram_wdata} !== 32'h0) begin
         n_fail++; $display("FAIL reset_ram_bus: got %h expected 0", {ram_addr, ram_wdata});
      end
      n_checks++;
      if ({if_rdata, mem_rdata} !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, mem_rdata});
      end
      n_checks++;
      if ({ram_en_1, if_ready_1, mem_ready_1, if_rdata_1} !== 19'h0) begin
         n_fail++; $display("FAIL reset_lat1: got %h expected 0", {ram_en_1, if_ready_1, mem_ready_1, if_rdata_1});
      end
   endtask

   task automatic test_if_read();
      int ic, mc, b0; logic [15:0] id, md; bit sok, to;
      b0 = bq_addr.size();
      drive_pair(1, 0, 16'h0004, 1'b0, 16'h0, 16'h0, ic, mc, id, md, sok, to);
      exp_if = ref_m[4]; last_mem = 0;
      n_checks++;
      if (to || ic != LAT + 1) begin n_fail++; $display("FAIL if_read_latency: got %0d expected %0d", ic, LAT + 1); end
      n_checks++;
      if (id !== 16'h1234) begin n_fail++; $display("FAIL if_read_data: got %h expected 1234", id); end
      n_checks++;
      if (!sok) begin n_fail++; $display("FAIL if_read_stall: got bad stall_fetch expected high until ready"); end
      n_checks++;
      if (bq_addr.size() != b0 + 1) begin
         n_fail++; $display("FAIL if_read_bursts: got %0d expected 1", bq_addr.size() - b0);
      end else begin
         n_checks++;
         if (bq_len[b0] != LAT || bq_addr[b0] !== 16'h0004 || bq_we[b0] !== 1'b0 || !bq_stable[b0]) begin
            n_fail++; $display("FAIL if_read_bus: got len %0d addr %h we %b stable %0d expected len %0d addr 0004 we 0 stable 1",
                               bq_len[b0], bq_addr[b0], bq_we[b0], bq_stable[b0], LAT);
         end
      end
   endtask

   task automatic test_mem_write();
      int ic, mc, b0; logic [15:0] id, md; bit sok, to;
      b0 = bq_addr.size();
      drive_pair(0, 1, 16'h0, 1'b1, 16'h0010, 16'hBEEF, ic, mc, id, md, sok, to);
      ref_m[16] = 16'hBEEF; last_mem = 1;
      n_checks++;
      if (to || mc != LAT + 1) begin n_fail++; $display("FAIL mem_write_latency: got %0d expected %0d", mc, LAT + 1); end
      n_checks++;
      if (md !== exp_mem) begin n_fail++; $display("FAIL mem_write_rdata_held: got %h expected %h", md, exp_mem); end
      n_checks++;
      if (bq_addr.size() != b0 + 1) begin
         n_fail++; $display("FAIL mem_write_bursts: got %0d expected 1", bq_addr.size() - b0);
      end else begin
         n_checks++;
         if (bq_len[b0] != LAT || bq_addr[b0] !== 16'h0010 || bq_we[b0] !== 1'b1 ||
             bq_wdata[b0] !== 16'hBEEF || !bq_stable[b0]) begin
            n_fail++; $display("FAIL mem_write_bus: got len %0d addr %h we %b wdata %h expected len %0d addr 0010 we 1 wdata beef",
                               bq_len[b0], bq_addr[b0], bq_we[b0], bq_wdata[b0], LAT);
         end
      end
      n_checks++;
      if (ram_m[16] !== ref_m[16]) begin n_fail++; $display("FAIL mem_write_stored: got %h expected %h", ram_m[16], ref_m[16]); end
   endtask

   task automatic test_arbitration();
      int cnt, cyc, b0; logic [15:0] got_if, got_mem;
      apply_reset();
      b0 = bq_addr.size(); cnt = 0; cyc = 0; got_if = '0; got_mem = '0;
      @(posedge clk); #1;
      if_req = 1; if_addr = 16'h0030; mem_req = 1; mem_we = 0; mem_addr = 16'h0020;
      while (cnt < 3 && cyc < 40) begin
         @(negedge clk);
         if (if_ready === 1'b1) begin cnt++; got_if = if_rdata; end
         if (mem_ready === 1'b1) begin cnt++; got_mem = mem_rdata; end
         @(posedge clk); #1;
         cyc++;
      end
      if_req = 0; mem_req = 0;
      exp_if = ref_m[48]; exp_mem = ref_m[32]; last_mem = 1;
      n_checks++;
      if (cnt != 3) begin n_fail++; $display("FAIL arb_ready_count: got %0d expected 3", cnt); end
      n_checks++;
      if (bq_addr.size() != b0 + 3) begin
         n_fail++; $display("FAIL arb_bursts: got %0d expected 3", bq_addr.size() - b0);
      end else begin
         n_checks++;
         if (bq_addr[b0] !== 16'h0020 || bq_addr[b0+1] !== 16'h0030 || bq_addr[b0+2] !== 16'h0020) begin
            n_fail++; $display("FAIL arb_order: got %h %h %h expected 0020 0030 0020",
                               bq_addr[b0], bq_addr[b0+1], bq_addr[b0+2]);
         end
      end
      n_checks++;
      if (got_if !== exp_if || got_mem !== exp_mem) begin
         n_fail++; $display("FAIL arb_data: got if %h mem %h expected if %h mem %h", got_if, got_mem, exp_if, exp_mem);
      end
   endtask

   task automatic test_mem_hog();
      int cyc, mem_seen; bit done; logic [15:0] a, d;
      @(posedge clk); #1;
      mem_req = 1; mem_we = 0; mem_addr = 16'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         a = 16'($urandom_range(0, 255));
         if_req = 1; if_addr = a; mem_seen = 0; cyc = 0; done = 0; d = '0;
         while (!done && cyc < 30) begin
            @(negedge clk);
            if (mem_ready === 1'b1) mem_seen++;
            if (if_ready === 1'b1) begin done = 1; d = if_rdata; end
            @(posedge clk); #1;
            cyc++;
         end
         if_req = 0;
         n_checks++;
         if (!done || cyc - 1 > 2 * LAT + 3) begin
            n_fail++; $display("FAIL hog_if_wait[%0d]: got %0d cycles expected at most %0d", k, cyc - 1, 2 * LAT + 3);
         end
         n_checks++;
         if (mem_seen > 1) begin n_fail++; $display("FAIL hog_mem_between[%0d]: got %0d expected at most 1", k, mem_seen); end
         n_checks++;
         if (d !== ref_m[a[7:0]]) begin n_fail++; $display("FAIL hog_if_data[%0d]: got %h expected %h", k, d, ref_m[a[7:0]]); end
      end
      mem_req = 0;
      repeat (2 * LAT + 4) @(posedge clk);
   endtask

   task automatic test_reset_mid_access();
      int ic, mc; logic [15:0] id, md; bit sok, to, any;
      drive_pair(1, 0, 16'h0004, 1'b0, 16'h0, 16'h0, ic, mc, id, md, sok, to);
      n_checks++;
      if (id !== ref_m[4]) begin n_fail++; $display("FAIL rst_mid_pre: got %h expected %h", id, ref_m[4]); end
      @(posedge clk); #1;
      if_req = 1; if_addr = 16'h0005;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1; if_req = 0;
      @(negedge clk);
      n_checks++;
      if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_access: got ram_en %b expected 1", ram_en); end
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      n_checks++;
      if ({ram_en, if_ready} !== 2'b00 || if_rdata !== 16'h0) begin
         n_fail++; $display("FAIL rst_mid_abort: got ram_en %b if_ready %b if_rdata %h expected 0 0 0000",
                            ram_en, if_ready, if_rdata);
      end
      any = 0;
      repeat (5) begin
         @(negedge clk);
         if (if_ready !== 1'b0 || ram_en !== 1'b0) any = 1;
      end
      n_checks++;
      if (any) begin n_fail++; $display("FAIL rst_mid_quiet: got activity after reset expected none"); end
      last_mem = 0; exp_if = '0; exp_mem = '0;
      drive_pair(1, 0, 16'h0006, 1'b0, 16'h0, 16'h0, ic, mc, id, md, sok, to);
      n_checks++;
      if (to || ic != LAT + 1 || id !== ref_m[6]) begin
         n_fail++; $display("FAIL rst_mid_cold: got lat %0d data %h expected lat %0d data %h", ic, id, LAT + 1, ref_m[6]);
      end
   endtask

   task automatic test_latency1();
      int cyc, p0, p1, e0; logic [15:0] d0, d1;
      e0 = en1_cnt; p0 = -1; p1 = -1; cyc = 0; d0 = '0; d1 = '0;
      @(posedge clk); #1;
      if_req_1 = 1; if_addr_1 = 16'h0000;
      while (p1 < 0 && cyc < 30) begin
         @(negedge clk);
         if (if_ready_1 === 1'b1) begin
            if (p0 < 0) begin p0 = cyc; d0 = if_rdata_1; end
            else begin p1 = cyc; d1 = if_rdata_1; end
         end
         @(posedge clk); #1;
         if (p0 >= 0) if_addr_1 = 16'h0001;
         if (p1 >= 0) if_req_1 = 0;
         cyc++;
      end
      if_req_1 = 0;
      n_checks++;
      if (p0 != LAT1 + 1) begin n_fail++; $display("FAIL lat1_first: got %0d expected %0d", p0, LAT1 + 1); end
      n_checks++;
      if (p1 < 0 || p1 - p0 != LAT1 + 2) begin n_fail++; $display("FAIL lat1_spacing: got %0d expected %0d", p1 - p0, LAT1 + 2); end
      n_checks++;
      if (d0 !== (init_val(0) ^ 16'hFFFF) || d1 !== (init_val(1) ^ 16'hFFFF)) begin
         n_fail++; $display("FAIL lat1_data: got %h %h expected %h %h", d0, d1, init_val(0) ^ 16'hFFFF, init_val(1) ^ 16'hFFFF);
      end
      n_checks++;
      if (en1_cnt - e0 != 2 * LAT1) begin n_fail++; $display("FAIL lat1_en_cycles: got %0d expected %0d", en1_cnt - e0, 2 * LAT1); end
   endtask

   task automatic test_random();
      int ic, mc, b0, exp_ic, exp_mc, pat; logic [15:0] id, md, ia, ma, mwd;
      bit sok, to, do_if, do_mem, mwe, mem_first;
      apply_reset();
      for (int n = 0; n < 30; n++) begin
         pat = $urandom_range(0, 2);
         do_if = (pat != 1); do_mem = (pat != 0);
         ia = 16'($urandom_range(0, 255)); ma = 16'($urandom_range(0, 255));
         mwe = 1'($urandom_range(0, 1)); mwd = 16'($urandom);
         // Reference: both pending -> MEM first unless MEM had the previous grant.
         mem_first = (do_if && do_mem) ? !last_mem : do_mem;
         exp_ic = (do_mem && mem_first) ? 2 * LAT + 3 : LAT + 1;
         exp_mc = (do_if && !mem_first) ? 2 * LAT + 3 : LAT + 1;
         for (int s = 0; s < 2; s++) begin
            if ((s == 0) == mem_first) begin
               if (do_mem) begin
                  if (mwe) ref_m[ma[7:0]] = mwd; else exp_mem = ref_m[ma[7:0]];
                  last_mem = 1;
               end
            end else if (do_if) begin
               exp_if = ref_m[ia[7:0]];
               last_mem = 0;
            end
         end
         b0 = bq_addr.size();
         drive_pair(do_if, do_mem, ia, mwe, ma, mwd, ic, mc, id, md, sok, to);
         n_checks++;
         if (to || !sok) begin n_fail++; $display("FAIL rnd_handshake[%0d]: got timeout %0d stall_ok %0d expected 0 1", n, to, sok); end
         if (do_if) begin
            n_checks++;
            if (ic != exp_ic || id !== exp_if) begin
               n_fail++; $display("FAIL rnd_if[%0d]: got cyc %0d data %h expected cyc %0d data %h", n, ic, id, exp_ic, exp_if);
            end
         end
         if (do_mem) begin
            n_checks++;
            if (mc != exp_mc || md !== exp_mem) begin
               n_fail++; $display("FAIL rnd_mem[%0d]: got cyc %0d data %h expected cyc %0d data %h", n, mc, md, exp_mc, exp_mem);
            end
         end
         n_checks++;
         if (bq_addr.size() - b0 != int'(do_if) + int'(do_mem)) begin
            n_fail++; $display("FAIL rnd_bursts[%0d]: got %0d expected %0d", n, bq_addr.size() - b0, int'(do_if) + int'(do_mem));
         end
      end
   endtask

   initial begin
      reset = 1;
      if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
      if_req_1 = 0; if_addr_1 = '0; mem_req_1 = 0; mem_we_1 = 0; mem_addr_1 = '0; mem_wdata_1 = '0;
      for (int i = 0; i < 256; i++) ref_m[i] = init_val(i);
      last_mem = 0; exp_if = '0; exp_mem = '0;
      test_reset();
      test_if_read();
      test_mem_write();
      test_arbitration();
      test_mem_hog();
      test_reset_mid_access();
      test_latency1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
